// File: rtl/multi_channel_random_roller.sv
// ============================================================================
// Module   : multi_channel_random_roller
// Purpose  : NUM_CH independent dice-style rollers. Each channel emits
//            decelerating pseudo-random updates after a start pulse, then
//            settles on a final value.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module multi_channel_random_roller #(
    parameter int          NUM_CH      = 2,
    parameter int          OUT_W       = 4,
    parameter int          MAX_VAL     = 15,
    parameter int          INIT_PERIOD = 2500000,
    parameter int          PERIOD_STEP = 1250000,
    parameter int          NUM_STEPS   = 16,
    parameter logic [15:0] SEED        = 16'hACE1
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic [NUM_CH-1:0]         i_start,
    input  logic [NUM_CH-1:0]         i_stop,
    output logic [NUM_CH*OUT_W-1:0]   o_value,
    output logic [NUM_CH-1:0]         o_busy,
    output logic [NUM_CH-1:0]         o_done
);

    // Sized for the longest interval so the period never wraps
    localparam int TW = $clog2(INIT_PERIOD + NUM_STEPS*PERIOD_STEP + 1);
    localparam int SW = $clog2(NUM_STEPS + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ROLL = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        localparam logic [15:0] C_SEED_RAW = SEED ^ 16'(16'h1D35 * (c + 1));
        localparam logic [15:0] C_SEED     = (C_SEED_RAW == 16'h0) ? SEED : C_SEED_RAW;

        state_t           state_q;
        logic [15:0]      lfsr_q;
        logic [15:0]      lfsr_d;
        logic [OUT_W-1:0] value_q;
        logic [OUT_W-1:0] w_raw;
        logic [OUT_W-1:0] w_map;
        logic [TW-1:0]    period_q;
        logic [TW-1:0]    period_d;
        logic [TW-1:0]    timer_q;
        logic [SW-1:0]    step_q;
        logic [SW-1:0]    step_d;
        logic             done_q;
        logic             w_fb;

        // x^16+x^14+x^13+x^11+1, right-shifting Fibonacci form
        assign w_fb     = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];
        assign lfsr_d   = {w_fb, lfsr_q[15:1]};

        // Fold out-of-range raw values back into 0..MAX_VAL
        assign w_raw    = lfsr_q[OUT_W-1:0];
        assign w_map    = (w_raw > OUT_W'(MAX_VAL)) ? (w_raw - OUT_W'(MAX_VAL + 1)) : w_raw;

        assign step_d   = step_q + SW'(1);
        assign period_d = period_q + TW'(PERIOD_STEP);

        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                state_q  <= S_IDLE;
                lfsr_q   <= C_SEED;
                value_q  <= '0;
                period_q <= '0;
                timer_q  <= '0;
                step_q   <= '0;
                done_q   <= 1'b0;
            end else begin
                lfsr_q <= lfsr_d;
                done_q <= 1'b0;
                if (i_start[c]) begin
                    state_q  <= S_ROLL;
                    period_q <= TW'(INIT_PERIOD);
                    timer_q  <= TW'(INIT_PERIOD);
                    step_q   <= '0;
                end else if (state_q == S_ROLL) begin
                    if (i_stop[c]) begin
                        value_q <= w_map;
                        state_q <= S_HOLD;
                        done_q  <= 1'b1;
                    end else if (timer_q == TW'(1)) begin
                        value_q  <= w_map;
                        step_q   <= step_d;
                        period_q <= period_d;
                        timer_q  <= period_d;
                        if (step_d == SW'(NUM_STEPS)) begin
                            state_q <= S_HOLD;
                            done_q  <= 1'b1;
                        end
                    end else begin
                        timer_q <= timer_q - TW'(1);
                    end
                end
            end
        end

        assign o_value[c*OUT_W +: OUT_W] = value_q;
        assign o_busy[c]                 = (state_q == S_ROLL);
        assign o_done[c]                 = done_q;
    end

endmodule

`default_nettype wire

// File: tb/tb_multi_channel_random_roller.sv
// ============================================================================
// Module   : tb_multi_channel_random_roller
// Purpose  : Scoreboard bench for multi_channel_random_roller with a
//            schedule-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_multi_channel_random_roller;

    localparam int NUM_CH = 2;
    localparam int OUT_W  = 4;
    localparam int MAXV   = 9;
    localparam int IP     = 4;
    localparam int PS     = 2;
    localparam int NS     = 3;

    logic                    clk   = 1'b0;
    logic                    rst_n = 1'b0;
    logic [NUM_CH-1:0]       start = '0;
    logic [NUM_CH-1:0]       stop  = '0;
    logic [NUM_CH*OUT_W-1:0] value;
    logic [NUM_CH-1:0]       busy;
    logic [NUM_CH-1:0]       done;

    multi_channel_random_roller #(
        .NUM_CH(NUM_CH), .OUT_W(OUT_W), .MAX_VAL(MAXV),
        .INIT_PERIOD(IP), .PERIOD_STEP(PS), .NUM_STEPS(NS), .SEED(16'hACE1)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_stop(stop),
        .o_value(value), .o_busy(busy), .o_done(done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [NUM_CH*OUT_W-1:0] value;
        logic [NUM_CH-1:0]       busy;
        logic [NUM_CH-1:0]       done;
    } snap_t;

    snap_t expq[$];
    int    checks = 0;
    int    errors = 0;
    bit    mon_en = 1'b0;

    int m_lfsr [NUM_CH];
    bit m_roll [NUM_CH];
    int m_e0   [NUM_CH];
    int m_k    [NUM_CH];
    int m_val  [NUM_CH];
    int t = 0;

    function automatic int lfsr_next(input int l);
        int b;
        b = (l ^ (l >> 2) ^ (l >> 3) ^ (l >> 5)) & 1;
        return (l >> 1) | (b << 15);
    endfunction

    function automatic int map_val(input int l);
        int r;
        r = l % 16;
        return (r > MAXV) ? r - (MAXV + 1) : r;
    endfunction

    function automatic int seed_of(input int c);
        int s;
        s = 16'hACE1 ^ ((16'h1D35 * (c + 1)) % 65536);
        return (s == 0) ? 16'hACE1 : s;
    endfunction

    function automatic int update_edge(input int e0, input int k);
        return e0 + k*IP + PS*k*(k-1)/2;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < NUM_CH; c++) begin
            m_lfsr[c] = seed_of(c);
            m_roll[c] = 1'b0;
            m_e0[c]   = 0;
            m_k[c]    = 0;
            m_val[c]  = 0;
        end
    endtask

    task automatic check_zero(input string name);
        checks++;
        if (value !== '0 || busy !== '0 || done !== '0) begin
            errors++;
            $display("FAIL %s: got value=%h busy=%b done=%b, need all zero", name, value, busy, done);
        end
    endtask

    // One clock of stimulus; model computes what the next edge must produce.
    task automatic cycle(input logic [NUM_CH-1:0] st, input logic [NUM_CH-1:0] sp, input bit rst_lvl);
        snap_t s;
        @(negedge clk);
        if (!rst_lvl && rst_n) begin
            #2 rst_n = 1'b0;
            #1 check_zero("async_reset");
        end else if (rst_lvl && !rst_n) begin
            rst_n = 1'b1;
        end
        start = rst_lvl ? st : '0;
        stop  = rst_lvl ? sp : '0;
        s = '0;
        if (!rst_lvl) begin
            model_reset();
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (st[c]) begin
                    m_roll[c] = 1'b1;
                    m_e0[c]   = t;
                    m_k[c]    = 0;
                end else if (m_roll[c]) begin
                    if (sp[c]) begin
                        m_val[c]  = map_val(m_lfsr[c]);
                        m_roll[c] = 1'b0;
                        s.done[c] = 1'b1;
                    end else if (t == update_edge(m_e0[c], m_k[c] + 1)) begin
                        m_val[c] = map_val(m_lfsr[c]);
                        m_k[c]++;
                        if (m_k[c] == NS) begin
                            m_roll[c] = 1'b0;
                            s.done[c] = 1'b1;
                        end
                    end
                end
                m_lfsr[c] = lfsr_next(m_lfsr[c]);
                s.value[c*OUT_W +: OUT_W] = OUT_W'(m_val[c]);
                s.busy[c] = m_roll[c];
            end
        end
        t++;
        expq.push_back(s);
        mon_en = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) cycle('0, '0, 1'b1);
    endtask

    initial begin : monitor
        snap_t e;
        forever begin
            @(posedge clk);
            #1;
            if (mon_en) begin
                checks++;
                if (expq.size() == 0) begin
                    errors++;
                    $display("FAIL scoreboard_empty: got output with no expectation at %0t", $time);
                end else begin
                    e = expq.pop_front();
                    if ({value, busy, done} !== e) begin
                        errors++;
                        $display("FAIL cycle_out t=%0t: got value=%h busy=%b done=%b, need value=%h busy=%b done=%b",
                                 $time, value, busy, done, e.value, e.busy, e.done);
                    end
                end
                for (int c = 0; c < NUM_CH; c++) begin
                    checks++;
                    if (value[c*OUT_W +: OUT_W] > OUT_W'(MAXV)) begin
                        errors++;
                        $display("FAIL range ch%0d: got %0d, need <= %0d", c, value[c*OUT_W +: OUT_W], MAXV);
                    end
                end
            end
        end
    end

    initial begin : driver
        model_reset();
        repeat (3) @(posedge clk);
        #1 check_zero("reset_state");
        idle(2);

        cycle(2'b01, 2'b00, 1'b1); idle(25);                             // full roll
        cycle(2'b01, 2'b00, 1'b1); idle(5);
        cycle(2'b01, 2'b00, 1'b1); idle(25);                             // restart at E0+6
        cycle(2'b01, 2'b00, 1'b1); idle(6);
        cycle(2'b00, 2'b01, 1'b1); idle(20);                             // stop at E0+7
        cycle(2'b01, 2'b00, 1'b1); idle(3);
        cycle(2'b10, 2'b10, 1'b1); idle(30);                             // start+stop on ch1
        cycle(2'b11, 2'b00, 1'b1); idle(4);
        cycle('0, '0, 1'b0); cycle('0, '0, 1'b0); idle(25);              // reset mid-roll

        for (int i = 0; i < 14000; i++) begin
            if (i % 3000 == 2999) begin
                cycle('0, '0, 1'b0);
                cycle('0, '0, 1'b0);
            end else begin
                cycle({($urandom_range(0, 24) == 0), ($urandom_range(0, 24) == 0)},
                      {($urandom_range(0, 29) == 0), ($urandom_range(0, 29) == 0)}, 1'b1);
            end
        end

        idle(2);
        @(posedge clk);
        #3;
        checks++;
        if (expq.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending, need 0", expq.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
